// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-packed-BCD converter using shift-add-3
// (double dabble), one input bit per clock. The result and overflow flag are
// held between conversions so the downstream display scanner always sees a
// coherent value. Overflowing inputs display as all-ones ("FFFFFFFF").
module bin2bcd_seq #(
  parameter int BIN_W   = 27,
  parameter int DIGITS  = 8,
  parameter int MAX_VAL = 99999999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  localparam logic [BIN_W-1:0] MAX_V    = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [BIN_W-1:0] shreg;
  logic [CNT_W-1:0] count;
  logic             ovf_pend;

  logic [ACC_W-1:0] acc_adj;
  logic [ACC_W-1:0] acc_next;
  logic [BIN_W-1:0] shreg_next;

  // Per-nibble add-3 correction; no carry ever crosses a digit boundary.
  function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = a[4*i +: 4];
      end
    end
    return r;
  endfunction

  // One double-dabble step: correct digits, then shift binary MSB into digit 0.
  always_comb begin
    acc_adj    = add3_digits(acc);
    acc_next   = {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
    shreg_next = {shreg[BIN_W-2:0], 1'b0};
  end

  // Conversion FSM; bcd/ovf only ever change on the done edge or on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
      acc      <= '0;
      shreg    <= '0;
      count    <= '0;
      ovf_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg    <= bin;
            acc      <= '0;
            count    <= '0;
            ovf_pend <= (bin > MAX_V);
            busy     <= 1'b1;
            state    <= S_SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        S_SHIFT: begin
          acc   <= acc_next;
          shreg <= shreg_next;
          count <= count + CNT_W'(1);
          if (count == LAST_CNT) begin
            state <= S_FINISH;
          end else begin
            state <= S_SHIFT;
          end
        end
        S_FINISH: begin
          bcd   <= ovf_pend ? '1 : acc;
          ovf   <= ovf_pend;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus random values,
// checked against an arithmetic (divide-by-ten) reference model.
module tb_bin2bcd_seq;

  localparam int LAT = 28;

  logic        clk;
  logic        rst;
  logic        start;
  logic [26:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        ovf;

  int vectors;
  int errors;
  logic [31:0] exp_bcd;
  logic        exp_ovf;

  bin2bcd_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division, all-ones on overflow.
  function automatic logic [31:0] model_bcd(input logic [26:0] v);
    logic [31:0] r;
    int unsigned x;
    x = 32'(v);
    r = 32'h0;
    if (x > 32'd99999999) begin
      r = 32'hFFFF_FFFF;
    end else begin
      for (int i = 0; i < 8; i++) begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic logic model_ovf(input logic [26:0] v);
    return (32'(v) > 32'd99999999);
  endfunction

  // Full conversion: start pulse, latency check, result check.
  task automatic run_conv(input logic [26:0] v, input string name);
    int lat;
    lat = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: got %b expected 1", name, busy);
    end
    @(negedge clk);
    start = 1'b0;
    bin   = 27'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    vectors++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT);
    end
    exp_bcd = model_bcd(v);
    exp_ovf = model_ovf(v);
    vectors++;
    if (bcd !== exp_bcd || ovf !== exp_ovf || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: got bcd=%h ovf=%b busy=%b expected bcd=%h ovf=%b busy=0",
               name, bcd, ovf, busy, exp_bcd, exp_ovf);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || bcd !== exp_bcd || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s_hold: got done=%b bcd=%h ovf=%b expected done=0 bcd=%h ovf=%b",
               name, done, bcd, ovf, exp_bcd, exp_ovf);
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    #12;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 32'h0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b bcd=%h ovf=%b expected all 0",
               busy, done, bcd, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_bcd = 32'h0;
    exp_ovf = 1'b0;
  endtask

  task automatic test_zero;
    run_conv(27'd0, "zero");
  endtask

  task automatic test_known;
    run_conv(27'd12345678, "dec_12345678");
    vectors++;
    if (bcd !== 32'h1234_5678) begin
      errors++;
      $display("FAIL const_12345678: got %h expected 12345678", bcd);
    end
    run_conv(27'd99999999, "max_val");
    vectors++;
    if (bcd !== 32'h9999_9999 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL const_max: got %h ovf=%b expected 99999999 ovf=0", bcd, ovf);
    end
  endtask

  task automatic test_overflow;
    run_conv(27'd100000000, "overflow");
    vectors++;
    if (bcd !== 32'hFFFF_FFFF || ovf !== 1'b1) begin
      errors++;
      $display("FAIL const_ovf: got %h ovf=%b expected ffffffff ovf=1", bcd, ovf);
    end
    run_conv(27'd7, "after_ovf");
    vectors++;
    if (bcd !== 32'h0000_0007 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL const_7: got %h ovf=%b expected 00000007 ovf=0", bcd, ovf);
    end
  endtask

  task automatic test_reset_mid_shift;
    int dones;
    dones = 0;
    // Leave a nonzero held result so the reset clearing is observable.
    run_conv(27'd4321, "pre_reset");
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd12345678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 32'h0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: got busy=%b done=%b bcd=%h ovf=%b expected all 0",
               busy, done, bcd, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0 || bcd !== 32'h0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d dones bcd=%h expected 0 dones bcd=0", dones, bcd);
    end
    run_conv(27'd12345678, "after_reset");
  endtask

  task automatic test_ignore_start;
    int dones;
    int first;
    dones = 0;
    first = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd42;
    @(posedge clk);
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      start = (i == 5 || i == 15) ? 1'b1 : 1'b0;
      bin   = start ? 27'd999 : 27'($urandom);
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        dones++;
        if (first == 0) first = i;
      end
    end
    exp_bcd = 32'h0000_0042;
    exp_ovf = 1'b0;
    vectors++;
    if (dones != 1 || first != LAT || bcd !== exp_bcd || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: got dones=%0d at %0d bcd=%h expected 1 at %0d bcd=%h",
               dones, first, bcd, LAT, exp_bcd);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_done;
    int   bad;
    bad = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd1;
    @(posedge clk);           // capture edge 0
    for (int e = 1; e <= 86; e++) begin
      @(negedge clk);
      if ((e - 1) % 29 == 0) bin = 27'((e - 1) / 29 + 2);
      if (e == 86) start = 1'b0;
      @(posedge clk);
      #1;
      exp_done = (e % 29 == 28);
      if (exp_done) begin
        exp_bcd = model_bcd(27'(e / 29 + 1));
        exp_ovf = 1'b0;
      end
      vectors++;
      if (done !== exp_done || bcd !== exp_bcd || ovf !== exp_ovf) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL b2b_edge%0d: got done=%b bcd=%h expected done=%b bcd=%h",
                   e, done, bcd, exp_done, exp_bcd);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (busy !== 1'b0 || bcd !== 32'h3) begin
      errors++;
      $display("FAIL b2b_stop: got busy=%b bcd=%h expected busy=0 bcd=00000003", busy, bcd);
    end
  endtask

  task automatic test_random;
    logic [26:0] v;
    for (int n = 0; n < 16; n++) begin
      if (n % 4 == 3) v = 27'($urandom);
      else v = 27'($urandom_range(99999999, 0));
      run_conv(v, "random");
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset;
    test_zero;
    test_known;
    test_overflow;
    test_reset_mid_shift;
    test_ignore_start;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
